mips_bus_arbiter: RTL
=====================

Name: mips_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the CPU's Avalon-style memory bus: address, read, write, writedata, byteenable, readdata, waitrequest.
- Master 0 is the instruction-fetch port; master 1 is the data load/store port.
- It shares the single RAM port between the two masters, one transaction at a time.
- It holds off the losing master with waitrequest and flags stalled transactions with a sticky error bit.

Parameters:
- PRIORITY_MODE, 0, 0 = round-robin between masters; 1 = fixed priority, master 1 (data) wins.
- MAX_WAIT, 255, number of consecutive slave-stall cycles in one grant before bus_error is set; 0 disables the check.
- WAIT_W, 8, width of the stall counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  reset, asynchronous and active-low (0 = reset)
- m0_address  input  32  fetch master address
- m0_read  input  1  fetch read request
- m0_write  input  1  fetch write request
- m0_writedata  input  32  fetch write data
- m0_byteenable  input  4  fetch byte enables
- m0_readdata  output  32  read data to master 0
- m0_waitrequest  output  1  stall to master 0
- m1_address, m1_read, m1_write, m1_writedata, m1_byteenable, m1_readdata, m1_waitrequest  same widths and directions as m0_*; data master
- s_address  output  32  to slave
- s_read  output  1  to slave
- s_write  output  1  to slave
- s_writedata  output  32  to slave
- s_byteenable  output  4  to slave
- s_readdata  input  32  from slave
- s_waitrequest  input  1  from slave
- grant  output  2  one-hot current owner: 01 = m0, 10 = m1, 00 = idle
- bus_error  output  1  sticky stall-timeout flag

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low.
- While rst = 0:
  - state = IDLE, grant = 00, bus_error = 0, stall counter = 0, last-winner = m1 (so m0 wins the first round-robin tie).
  - s_read = s_write = 0; s_address, s_writedata, s_byteenable = 0.
  - m0_waitrequest = m1_waitrequest = 1.
- Request definition: reqX = mX_read | mX_write. Masters hold all request signals stable until they see waitrequest = 0 (Avalon rule).
- FSM states: IDLE, GNT0, GNT1.
- IDLE:
  - No slave strobes driven; both m*_waitrequest = 1.
  - Next state is chosen from req0/req1 sampled at the rising edge.
  - Only one requesting: grant it.
  - Both requesting: round-robin grants the master that is not last-winner; fixed mode grants m1.
  - Arbitration latency is 1 cycle: a request arriving in IDLE sees slave strobes no earlier than the next cycle.
- GNTx:
  - s_* is a combinational mux of master x's signals.
  - mx_waitrequest = s_waitrequest; the other master's waitrequest = 1.
  - Both mX_readdata = s_readdata; masters qualify readdata themselves.
- Completion: the cycle in GNTx where reqx = 1 and s_waitrequest = 0. At the following edge:
  - last-winner <= x and the stall counter clears.
  - If the other master is requesting, go directly to its GNT state (back-to-back, no idle cycle). Otherwise go to IDLE.
  - The completing master is never re-granted directly; it re-arbitrates through IDLE. This stops the fetch stream from starving data.
- Abort: if reqx drops in GNTx before completion (protocol violation), return to IDLE next edge; last-winner is unchanged.
- Stall counter:
  - Increments each GNTx cycle with reqx = 1 and s_waitrequest = 1.
  - Saturates at 2^WAIT_W − 1.
  - When it reaches MAX_WAIT (MAX_WAIT ≠ 0), bus_error <= 1. The flag stays set until reset.
  - The transaction is not aborted.
- Simultaneous read and write from one master is passed through unchanged; the arbiter does no checking.
- Reset asserted mid-transaction: all outputs go immediately to reset values; the slave sees its strobes drop.

Decomposition:
- Shared package (mips_bus_pkg): state enum {IDLE, GNT0, GNT1}; GRANT_NONE/GRANT_M0/GRANT_M1 one-hot constants; a bus request struct (address, read, write, writedata, byteenable) reusable by the CPU bus interface.
- Natural sub-module: mips_bus_rr_pick. It is combinational and takes req0, req1, last_winner and PRIORITY_MODE, returning the next grant. It is unit-testable alone.
- The FSM, mux and stall counter stay in mips_bus_arbiter.

Test Plan:
- Single master: m0 reads 0xBFC00000 against a slave with 1-cycle waitrequest → grant = 01 one cycle after request. s_address = 0xBFC00000. m0_waitrequest low exactly one cycle, with s_readdata passed through. Then IDLE.
- Contention, round-robin: both request from IDLE → m0 granted first. On m0 completion, m1 granted with no idle cycle. m1 writes 0x12345678 with byteenable 0xF → slave sees it intact. m1_waitrequest stays 1 throughout m0's grant.
- Fixed priority (PRIORITY_MODE = 1): repeat the contention case → m1 granted first, m0 second.
- Stall timeout: MAX_WAIT = 4, slave holds waitrequest = 1 for 6 cycles → bus_error rises after the 4th stall cycle and remains 1 after completion. Only async reset clears it.
- Reset mid-transaction: drop rst while in GNT1 with s_write = 1 → s_write = 0, grant = 00 and both waitrequests = 1 without waiting for a clock edge. After release, the first contention grants m0.
- Abort: m0 deasserts read in GNT0 while the slave is stalling → IDLE next cycle. A pending m1 is granted the following cycle.

Source files
------------

// File: rtl/mips_bus_pkg.sv
// -----------------------------------------------------------------------------
// mips_bus_pkg
// Shared types and constants for the CPU memory-bus arbiter and any CPU-side
// bus interface that wants to carry a complete Avalon-style request as a
// single value.
//
// Contents:
//   bus_state_e    arbiter FSM states (IDLE, GNT0, GNT1)
//   GRANT_*        one-hot grant encodings (bit 0 = fetch master, bit 1 = data)
//   bus_req_t      one master's request bundle (address/read/write/data/be)
//   BUS_REQ_IDLE   request value meaning "nothing on the bus"
//   bus_req_active helper: a request is live when read or write is high
// -----------------------------------------------------------------------------
package mips_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } bus_state_e;

  localparam logic [1:0] GRANT_NONE = 2'b00;
  localparam logic [1:0] GRANT_M0   = 2'b01;
  localparam logic [1:0] GRANT_M1   = 2'b10;

  typedef struct packed {
    logic [31:0] address;
    logic        read;
    logic        write;
    logic [31:0] writedata;
    logic [3:0]  byteenable;
  } bus_req_t;

  localparam bus_req_t BUS_REQ_IDLE = '{
    address:    32'h0000_0000,
    read:       1'b0,
    write:      1'b0,
    writedata:  32'h0000_0000,
    byteenable: 4'h0
  };

  // A master is requesting whenever either strobe is high; a simultaneous
  // read+write still counts as one request and is passed through as-is.
  function automatic logic bus_req_active(input bus_req_t req);
    return req.read | req.write;
  endfunction

endpackage

// File: rtl/mips_bus_rr_pick.sv
// -----------------------------------------------------------------------------
// mips_bus_rr_pick
// Combinational arbitration decision used when the bus is idle.
//
// Parameters:
//   PRIORITY_MODE  0 = round-robin on a tie, 1 = data master (m1) always wins
//
// Ports:
//   i_req0         fetch master requesting
//   i_req1         data master requesting
//   i_last_winner  master that completed most recently (0 = m0, 1 = m1)
//   o_grant        one-hot winner, GRANT_NONE when nobody requests
// -----------------------------------------------------------------------------
module mips_bus_rr_pick
  import mips_bus_pkg::*;
#(
  parameter int PRIORITY_MODE = 0
) (
  input  logic       i_req0,
  input  logic       i_req1,
  input  logic       i_last_winner,
  output logic [1:0] o_grant
);

  // Winner selection: a lone requester always wins; a tie goes to m1 in
  // fixed mode, otherwise to whichever master did not win last time.
  always_comb begin
    o_grant = GRANT_NONE;
    case ({i_req1, i_req0})
      2'b01: o_grant = GRANT_M0;
      2'b10: o_grant = GRANT_M1;
      2'b11: begin
        if (PRIORITY_MODE != 0) begin
          o_grant = GRANT_M1;
        end else if (i_last_winner) begin
          o_grant = GRANT_M0;
        end else begin
          o_grant = GRANT_M1;
        end
      end
      default: o_grant = GRANT_NONE;
    endcase
  end

endmodule

// File: rtl/mips_bus_arbiter.sv
// -----------------------------------------------------------------------------
// mips_bus_arbiter
// Shares one Avalon-style RAM port between the instruction-fetch master (m0)
// and the data load/store master (m1), one transaction at a time. The master
// that does not own the bus is held off with waitrequest. A sticky flag
// records any grant in which the slave stalled for MAX_WAIT cycles in a row.
//
// Parameters:
//   PRIORITY_MODE  0 = round-robin, 1 = fixed priority with m1 winning
//   MAX_WAIT       consecutive slave-stall cycles that set bus_error (0 = off)
//   WAIT_W         stall counter width, 2**WAIT_W must exceed MAX_WAIT
//
// Ports:
//   clk, rst               clock; asynchronous active-low reset
//   m0_* / m1_*            master-side Avalon ports (address, read, write,
//                          writedata, byteenable in; readdata, waitrequest out)
//   s_*                    slave-side Avalon port (strobes out, readdata and
//                          waitrequest in)
//   grant                  one-hot current owner, 00 when idle
//   bus_error              sticky stall-timeout flag, cleared only by reset
// -----------------------------------------------------------------------------
module mips_bus_arbiter
  import mips_bus_pkg::*;
#(
  parameter int PRIORITY_MODE = 0,
  parameter int MAX_WAIT      = 255,
  parameter int WAIT_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  // fetch master
  input  logic [31:0] m0_address,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_byteenable,
  output logic [31:0] m0_readdata,
  output logic        m0_waitrequest,
  // data master
  input  logic [31:0] m1_address,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_byteenable,
  output logic [31:0] m1_readdata,
  output logic        m1_waitrequest,
  // slave
  output logic [31:0] s_address,
  output logic        s_read,
  output logic        s_write,
  output logic [31:0] s_writedata,
  output logic [3:0]  s_byteenable,
  input  logic [31:0] s_readdata,
  input  logic        s_waitrequest,
  // status
  output logic [1:0]  grant,
  output logic        bus_error
);

  localparam logic [WAIT_W-1:0] CNT_MAX     = {WAIT_W{1'b1}};
  localparam logic [WAIT_W-1:0] CNT_ZERO    = {WAIT_W{1'b0}};
  localparam logic [WAIT_W-1:0] CNT_ONE     = {{(WAIT_W-1){1'b0}}, 1'b1};
  localparam logic [WAIT_W-1:0] MAX_WAIT_W  = WAIT_W'(MAX_WAIT);
  localparam logic              TIMEOUT_ON  = (MAX_WAIT != 0);

  bus_state_e        r_state;
  bus_state_e        w_state_next;
  logic              r_last_winner;   // 0 = m0, 1 = m1
  logic [WAIT_W-1:0] r_stall_cnt;
  logic [WAIT_W-1:0] w_stall_cnt_next;
  logic              r_bus_error;

  bus_req_t          w_m0_req;
  bus_req_t          w_m1_req;
  bus_req_t          w_sel_req;
  logic              w_req0;
  logic              w_req1;
  logic              w_own_req;
  logic              w_stall;
  logic              w_done;
  logic [1:0]        w_pick;

  assign w_m0_req = '{
    address:    m0_address,
    read:       m0_read,
    write:      m0_write,
    writedata:  m0_writedata,
    byteenable: m0_byteenable
  };

  assign w_m1_req = '{
    address:    m1_address,
    read:       m1_read,
    write:      m1_write,
    writedata:  m1_writedata,
    byteenable: m1_byteenable
  };

  assign w_req0 = bus_req_active(w_m0_req);
  assign w_req1 = bus_req_active(w_m1_req);

  mips_bus_rr_pick #(
    .PRIORITY_MODE (PRIORITY_MODE)
  ) u_pick (
    .i_req0        (w_req0),
    .i_req1        (w_req1),
    .i_last_winner (r_last_winner),
    .o_grant       (w_pick)
  );

  // Request of the current owner; zero while idle so stall/done stay quiet.
  always_comb begin
    w_own_req = 1'b0;
    case (r_state)
      GNT0:    w_own_req = w_req0;
      GNT1:    w_own_req = w_req1;
      default: w_own_req = 1'b0;
    endcase
  end

  assign w_stall = w_own_req &  s_waitrequest;
  assign w_done  = w_own_req & ~s_waitrequest;

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // FSM next state. A completing owner never keeps the bus: it hands over to
  // a waiting peer back-to-back or drops to IDLE, so the fetch stream cannot
  // starve data accesses. A request that vanishes mid-grant is an abort.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        case (w_pick)
          GRANT_M0: w_state_next = GNT0;
          GRANT_M1: w_state_next = GNT1;
          default:  w_state_next = IDLE;
        endcase
      end
      GNT0: begin
        if (!w_req0) begin
          w_state_next = IDLE;
        end else if (!s_waitrequest) begin
          w_state_next = w_req1 ? GNT1 : IDLE;
        end else begin
          w_state_next = GNT0;
        end
      end
      GNT1: begin
        if (!w_req1) begin
          w_state_next = IDLE;
        end else if (!s_waitrequest) begin
          w_state_next = w_req0 ? GNT0 : IDLE;
        end else begin
          w_state_next = GNT1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: slave port is a straight mux of the owner's signals, the
  // owner sees the slave's waitrequest and everyone else is held off.
  always_comb begin
    w_sel_req      = BUS_REQ_IDLE;
    m0_waitrequest = 1'b1;
    m1_waitrequest = 1'b1;
    grant          = GRANT_NONE;
    case (r_state)
      GNT0: begin
        w_sel_req      = w_m0_req;
        m0_waitrequest = s_waitrequest;
        grant          = GRANT_M0;
      end
      GNT1: begin
        w_sel_req      = w_m1_req;
        m1_waitrequest = s_waitrequest;
        grant          = GRANT_M1;
      end
      default: begin
        w_sel_req      = BUS_REQ_IDLE;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = GRANT_NONE;
      end
    endcase
  end

  assign s_address    = w_sel_req.address;
  assign s_read       = w_sel_req.read;
  assign s_write      = w_sel_req.write;
  assign s_writedata  = w_sel_req.writedata;
  assign s_byteenable = w_sel_req.byteenable;

  // Read data goes to both masters; each qualifies it with its own
  // waitrequest.
  assign m0_readdata = s_readdata;
  assign m1_readdata = s_readdata;

  // Last-winner tracking; reset to m1 so m0 wins the first tie. Aborts leave
  // it untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_winner <= 1'b1;
    end else if (w_done) begin
      r_last_winner <= (r_state == GNT1);
    end else begin
      r_last_winner <= r_last_winner;
    end
  end

  // Consecutive-stall count: saturating increment while the owner is held
  // by the slave, cleared by anything else (completion, abort, idle).
  always_comb begin
    w_stall_cnt_next = CNT_ZERO;
    if (w_stall) begin
      if (r_stall_cnt == CNT_MAX) begin
        w_stall_cnt_next = CNT_MAX;
      end else begin
        w_stall_cnt_next = r_stall_cnt + CNT_ONE;
      end
    end else begin
      w_stall_cnt_next = CNT_ZERO;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= CNT_ZERO;
    end else begin
      r_stall_cnt <= w_stall_cnt_next;
    end
  end

  // Sticky timeout flag: set on the edge where the count reaches MAX_WAIT;
  // the transaction itself is allowed to continue.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_error <= 1'b0;
    end else if (TIMEOUT_ON && w_stall && (w_stall_cnt_next == MAX_WAIT_W)) begin
      r_bus_error <= 1'b1;
    end else begin
      r_bus_error <= r_bus_error;
    end
  end

  assign bus_error = r_bus_error;

endmodule
